// File: rtl/result_writer_pkg.sv
// Shared types for the PE result path: writer FSM states and the packed
// 4x8-bit result word layout (r0 in the most significant byte).
package result_writer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RES = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } rw_state_t;

    localparam int RES_BYTES  = 4;
    localparam int RES_BYTE_W = 8;
    localparam int RES_W      = RES_BYTES * RES_BYTE_W;

    typedef struct packed {
        logic [RES_BYTE_W-1:0] r0;
        logic [RES_BYTE_W-1:0] r1;
        logic [RES_BYTE_W-1:0] r2;
        logic [RES_BYTE_W-1:0] r3;
    } res_word_t;

    // Zero every byte whose sign bit is set; non-negative bytes pass through.
    function automatic logic [RES_W-1:0] relu_word(input logic [RES_W-1:0] w);
        logic [RES_W-1:0] r;
        r = w;
        for (int i = 0; i < RES_BYTES; i++) begin
            if (w[i*RES_BYTE_W + RES_BYTE_W-1])
                r[i*RES_BYTE_W +: RES_BYTE_W] = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/out_addr_counter.sv
// Per-frame word counter with terminal-count flag; clr wins over en.
module out_addr_counter #(
    parameter int W     = 8,
    parameter int COUNT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] valOut,
    output logic         last
);

    localparam logic [W-1:0] LAST_VAL = W'(COUNT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valOut <= '0;
        else if (clr)
            valOut <= '0;
        else if (en)
            valOut <= valOut + W'(1);
    end

    assign last = (valOut == LAST_VAL);

endmodule

// File: rtl/result_writer.sv
// Drains packed PE result words into output memory, one word per
// handshake, at consecutive addresses starting from BASE_ADDR.
module result_writer
    import result_writer_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0,
    parameter int WORD_COUNT = 16,
    parameter int RELU       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RES_W-1:0]  resIn,
    input  logic              resValid,
    output logic              resAck,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [RES_W-1:0]  memData,
    input  logic              memReady,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    rw_state_t         state, state_nxt;
    logic [RES_W-1:0]  dataReg;
    logic [ADDR_W-1:0] wordCnt;
    logic              cntLast;
    logic              cntClr;
    logic              cntEn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dataReg <= '0;
        else if (state == WAIT_RES && resValid)
            dataReg <= (RELU != 0) ? relu_word(resIn) : resIn;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)    state_nxt = WAIT_RES;
            WAIT_RES: if (resValid) state_nxt = WRITE;
            WRITE:    if (memReady) state_nxt = cntLast ? DONE : WAIT_RES;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Counter holds on the last word; it is cleared by the next start.
    assign cntClr = (state == IDLE) && start;
    assign cntEn  = (state == WRITE) && memReady && !cntLast;

    out_addr_counter #(
        .W     (ADDR_W),
        .COUNT (WORD_COUNT)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cntClr),
        .en     (cntEn),
        .valOut (wordCnt),
        .last   (cntLast)
    );

    always_comb begin
        resAck  = 1'b0;
        memWe   = 1'b0;
        memAddr = '0;
        memData = '0;
        busy    = (state != IDLE);
        done    = (state == DONE);
        if (state == WAIT_RES)
            resAck = resValid;
        if (state == WRITE) begin
            memWe   = 1'b1;
            memAddr = BASE + wordCnt;
            memData = dataReg;
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Randomized scoreboard bench: instance 0 uses defaults (RELU=0), instance 1
// uses BASE_ADDR=250, WORD_COUNT=8, RELU=1 to cover address wrap and clamping.
module tb_result_writer;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        start    [2];
    logic [31:0] resIn    [2];
    logic        resValid [2];
    logic        resAck   [2];
    logic        memWe    [2];
    logic [7:0]  memAddr  [2];
    logic [31:0] memData  [2];
    logic        memReady [2];
    logic        busy     [2];
    logic        done     [2];

    exp_t sb [2][$];
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt [2] = '{0, 0};
    int   exp_done [2] = '{0, 0};
    logic rdy_rand [2] = '{1'b0, 1'b0};
    logic rdy_val  [2] = '{1'b1, 1'b1};

    logic        pend [2] = '{1'b0, 1'b0};
    logic        pk   [2] = '{1'b0, 1'b0};
    logic [7:0]  pa   [2];
    logic [31:0] pd   [2];

    result_writer u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .resIn(resIn[0]),
        .resValid(resValid[0]), .resAck(resAck[0]), .memWe(memWe[0]),
        .memAddr(memAddr[0]), .memData(memData[0]), .memReady(memReady[0]),
        .busy(busy[0]), .done(done[0])
    );

    result_writer #(.ADDR_W(8), .BASE_ADDR(250), .WORD_COUNT(8), .RELU(1)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .resIn(resIn[1]),
        .resValid(resValid[1]), .resAck(resAck[1]), .memWe(memWe[1]),
        .memAddr(memAddr[1]), .memData(memData[1]), .memReady(memReady[1]),
        .busy(busy[1]), .done(done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        for (int g = 0; g < 2; g++)
            memReady[g] = rdy_rand[g] ? ($urandom_range(0, 3) != 0) : rdy_val[g];
    end

    // Reference: negative bytes become zero when the instance clamps.
    function automatic logic [31:0] exp_data(input int g, input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  b;
        r = w;
        if (g == 1) begin
            for (int i = 0; i < 4; i++) begin
                b = w[8*i +: 8];
                if ($signed(b) < 0) r[8*i +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

    // Monitor: pops expected writes, checks stall stability and ack rules.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                pend[g] = 1'b0;
                pk[g]   = 1'b0;
            end else begin
                if (pend[g]) begin
                    checks++;
                    if (!(memWe[g] && memAddr[g] == pa[g] && memData[g] == pd[g] && !resAck[g])) begin
                        errs++;
                        $display("FAIL stall_hold[%0d]: we=%0b addr=%0d data=%h ack=%0b, want we=1 addr=%0d data=%h ack=0",
                                 g, memWe[g], memAddr[g], memData[g], resAck[g], pa[g], pd[g]);
                    end
                end
                if (pk[g]) begin
                    checks++;
                    if (resAck[g]) begin
                        errs++;
                        $display("FAIL ack_in_write[%0d]: ack=1 in cycle after an ack, want 0", g);
                    end
                end
                if (resAck[g]) begin
                    checks++;
                    if (done[g] || memWe[g]) begin
                        errs++;
                        $display("FAIL ack_overlap[%0d]: ack=1 done=%0b we=%0b, want done=0 we=0", g, done[g], memWe[g]);
                    end
                end
                if (done[g]) done_cnt[g]++;
                if (memWe[g] && memReady[g]) begin
                    checks++;
                    if (sb[g].size() == 0) begin
                        errs++;
                        $display("FAIL extra_write[%0d]: addr=%0d data=%h, want no write", g, memAddr[g], memData[g]);
                    end else begin
                        e = sb[g].pop_front();
                        if (memAddr[g] != e.addr || memData[g] != e.data) begin
                            errs++;
                            $display("FAIL write[%0d]: addr=%0d data=%h, want addr=%0d data=%h",
                                     g, memAddr[g], memData[g], e.addr, e.data);
                        end
                    end
                end
                pend[g] = memWe[g] && !memReady[g];
                pa[g]   = memAddr[g];
                pd[g]   = memData[g];
                pk[g]   = resAck[g];
            end
        end
    end

    // mode: 0 random, 1 back-to-back timing, 2 stall on word 3,
    //       3 reset during write of word 5, 4 start pulsed mid-frame
    task automatic run_frame(input int g, input int mode);
        int base, wc, t0, gap;
        bit ok;
        logic [31:0] w;
        base = (g == 1) ? 250 : 0;
        wc   = (g == 1) ? 8 : 16;
        rdy_rand[g] = (mode == 0 || mode == 4);
        rdy_val[g]  = 1'b1;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        t0 = cyc;
        for (int i = 0; i < wc; i++) begin
            if (mode == 4 && i == wc / 2) begin
                start[g] = 1'b1;
                @(posedge clk); #1;
                start[g] = 1'b0;
            end
            gap = (mode == 1) ? 0 : $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            w = (i == 0 && (mode == 1 || g == 1)) ? 32'h807F_FF01 : $urandom;
            if ((mode == 2 && i == 3) || (mode == 3 && i == 5)) rdy_val[g] = 1'b0;
            sb[g].push_back('{8'((base + i) % 256), exp_data(g, w)});
            resIn[g]    = w;
            resValid[g] = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (resAck[g]) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                errs++; checks++;
                $display("FAIL ack_timeout[%0d]: no ack for word %0d, want ack", g, i);
                resValid[g] = 1'b0;
                return;
            end
            @(posedge clk); #1;
            resValid[g] = 1'b0;
            if (mode == 2 && i == 3) begin
                repeat (5) @(posedge clk);
                #1 rdy_val[g] = 1'b1;
            end
            if (mode == 3 && i == 5) begin
                @(negedge clk); #2;
                rst[g] = 1'b1;
                #1;
                checks++;
                if (busy[g] || memWe[g] || resAck[g] || done[g] || memAddr[g] != 8'd0 || memData[g] != 32'd0) begin
                    errs++;
                    $display("FAIL mid_reset[%0d]: busy=%0b we=%0b ack=%0b done=%0b addr=%0d data=%h, want all 0",
                             g, busy[g], memWe[g], resAck[g], done[g], memAddr[g], memData[g]);
                end
                sb[g].delete();
                repeat (2) @(posedge clk);
                #1 rst[g] = 1'b0;
                rdy_val[g] = 1'b1;
                return;
            end
        end
        exp_done[g]++;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done[g]) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL done_timeout[%0d]: done never seen, want pulse", g);
        end else if (mode == 1 && cyc - t0 != 32) begin
            errs++;
            $display("FAIL frame_cycles[%0d]: %0d cycles from WAIT_RES to DONE, want 32", g, cyc - t0);
        end
        @(posedge clk); #1;
        checks++;
        if (busy[g] || done[g]) begin
            errs++;
            $display("FAIL idle_after_done[%0d]: busy=%0b done=%0b, want 0 0", g, busy[g], done[g]);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; start[g] = 1'b0; resIn[g] = 32'h0; resValid[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (busy[g] || done[g] || memWe[g] || resAck[g] || memAddr[g] != 8'd0 || memData[g] != 32'd0) begin
                errs++;
                $display("FAIL reset_state[%0d]: busy=%0b done=%0b we=%0b ack=%0b addr=%0d data=%h, want all 0",
                         g, busy[g], done[g], memWe[g], resAck[g], memAddr[g], memData[g]);
            end
        end
        // Stray valid while idle must not be acked.
        resValid[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (resAck[0]) begin
            errs++;
            $display("FAIL idle_ack: ack=1 in IDLE, want 0");
        end
        @(posedge clk); #1;
        resValid[0] = 1'b0;
        fork
            begin
                run_frame(0, 1);
                run_frame(0, 2);
                run_frame(0, 3);
                run_frame(0, 0);
                run_frame(0, 4);
                run_frame(0, 0);
                run_frame(0, 0);
            end
            begin
                for (int f = 0; f < 5; f++) run_frame(1, 0);
            end
        join
        repeat (4) @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (done_cnt[g] != exp_done[g] || sb[g].size() != 0) begin
                errs++;
                $display("FAIL frame_summary[%0d]: done pulses=%0d pending=%0d, want done pulses=%0d pending=0",
                         g, done_cnt[g], sb[g].size(), exp_done[g]);
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter ADDR_W, default 8: width of the output-memory word address.
REQ-002 Parameter BASE_ADDR, default 0: address of the first word written per frame.
REQ-003 Parameter WORD_COUNT, default 16 (legal 1..2^ADDR_W): number of result words per frame.
REQ-004 Parameter RELU, default 0: when 1, clamp negative result bytes to zero.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin a frame; sampled only in IDLE.
REQ-008 resIn  input  32  packed result word {r0,r1,r2,r3}, r0 in [31:24], each byte signed 8-bit.
REQ-009 resValid  input  1  producer holds a full result word; driven from the PE rbFull.
REQ-010 resAck  output  1  one-cycle acceptance pulse; drives the PE rbClear.
REQ-011 memWe  output  1  output-memory write request.
REQ-012 memAddr  output  ADDR_W  write address.
REQ-013 memData  output  32  write data.
REQ-014 memReady  input  1  memory accepts the write in any cycle where memWe and memReady are both high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at frame end.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_RES, WRITE and DONE.
REQ-018 IDLE with start=1 SHALL clear wordCnt to 0 and go to WAIT_RES; start in any other state SHALL be ignored.
REQ-019 In WAIT_RES, resAck SHALL equal resValid combinationally; on that edge dataReg SHALL capture the processed resIn and the FSM SHALL go to WRITE.
REQ-020 With RELU=1, each byte with bit 7 set SHALL become 8'h00 at capture; other bytes, and all bytes with RELU=0, SHALL pass unchanged.
REQ-021 resAck SHALL be 0 outside WAIT_RES, including when resValid is high during WRITE; the producer holds its data until acked.
REQ-022 In WRITE: memWe=1, memData=dataReg, memAddr=(BASE_ADDR+wordCnt) mod 2^ADDR_W; all three SHALL stay stable until memReady=1.
REQ-023 On an accepted write with wordCnt==WORD_COUNT-1, the FSM SHALL go to DONE; otherwise wordCnt SHALL increment and the FSM SHALL go to WAIT_RES.
REQ-024 DONE SHALL assert done for exactly one cycle and then go to IDLE; done and resAck SHALL never be high in the same cycle.
REQ-025 Minimum throughput SHALL be one word per 2 cycles (WAIT_RES→WRITE with memReady=1).
REQ-026 WORD_COUNT=1 SHALL produce exactly one write and then DONE.
REQ-027 memWe SHALL be 0 in IDLE, WAIT_RES and DONE.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, wordCnt=0, dataReg=0, and resAck=memWe=busy=done=0 with memAddr=memData=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no further write or ack; a new start after release SHALL begin at BASE_ADDR.

Structure
REQ-030 The state encoding and the packed-word byte layout (4×8-bit, r0 in the MSB byte) SHALL live in the shared package used by the PE blocks.
REQ-031 The word counter with its terminal-count compare SHALL be the sub-module out_addr_counter (ports clk, rst, clr, en, valOut, last).

Verification
REQ-032 Default parameters, start, 16 words each presented with resValid=1 and memReady=1: writes to addresses 0..15 in order, 16 resAck pulses, done exactly once, 32 cycles from the first WAIT_RES to DONE.
REQ-033 memReady held low for 5 cycles on word 3: memWe, memAddr=3 and memData stay constant, and no resAck occurs until the write is accepted.
REQ-034 RELU=1 with resIn=32'h80_7F_FF_01: memData=32'h00_7F_00_01. With RELU=0: memData=32'h80_7F_FF_01.
REQ-035 BASE_ADDR=250, ADDR_W=8, WORD_COUNT=8: addresses 250..255 then 0, 1.
REQ-036 rst pulsed while in WRITE of word 5, then start: busy=0 immediately on rst, and the next write goes to BASE_ADDR.
REQ-037 start pulsed mid-frame and resValid high during WRITE: both ignored, with no extra ack and no restart.
